spi_rx_buffer: RTL and testbench
================================

SPI_RX_BUFFER -- requirements
Module: spi_rx_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of 2, 2..64).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops on done (2..3).
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 done  input  1  SPI slave frame-complete level; asynchronous to capture logic.
REQ-006 dout  input  12  SPI slave received word; stable while done is high.
REQ-007 rx_ready  input  1  consumer accepts the head word.
REQ-008 ovf_clr  input  1  clears sticky overflow.
REQ-009 rx_data  output  12  head-of-FIFO word.
REQ-010 rx_valid  output  1  FIFO not empty.
REQ-011 level  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 full  output  1  level == DEPTH.
REQ-013 overflow  output  1  sticky: a frame was dropped.

Function
REQ-014 done SHALL pass through SYNC_STAGES flops before any use.
REQ-015 Capture FSM SHALL have states ARMED and HOLD.
REQ-016 ARMED: on synchronized done == 1, issue a one-cycle push of dout and go to HOLD.
REQ-017 HOLD: stay until synchronized done == 0, then go to ARMED.
REQ-018 Each done high pulse SHALL cause exactly one push, regardless of pulse length.
REQ-019 dout SHALL be sampled in the push cycle, registered with no synchronizer.
REQ-020 Latency: done rising edge to rx_valid high SHALL be SYNC_STAGES+1 clk cycles (empty FIFO).
REQ-021 Pop SHALL occur when rx_valid && rx_ready; rx_data SHALL show the next word (or hold) the following cycle.
REQ-022 rx_data SHALL be valid, first-word-fall-through, whenever rx_valid is high.
REQ-023 Push while full with no pop SHALL drop the new word and set overflow; FIFO contents SHALL be unchanged.
REQ-024 Push and pop in the same cycle while full SHALL both succeed; level SHALL be unchanged.
REQ-025 Push and pop in the same cycle with level between 1 and DEPTH-1 SHALL leave level unchanged.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from level.
REQ-027 ovf_clr SHALL clear overflow next cycle; a simultaneous drop SHALL win and overflow SHALL stay 1.

Reset
REQ-028 rst SHALL asynchronously clear the synchronizer, FSM (to ARMED), pointers, level and overflow.
REQ-029 During reset: rx_valid=0, full=0, level=0, overflow=0, rx_data=12'h000.
REQ-030 Reset mid-frame SHALL discard all stored words.
REQ-031 If done is still high at reset release, the FSM SHALL capture it as a new frame.

Configuration
REQ-032 With SPI_RX_DROP_CNT_EN defined: add output drop_cnt, 8 bits, the count of dropped frames.
REQ-033 drop_cnt SHALL saturate at 8'hFF, clear on rst and on ovf_clr, and count on the same cycles that set overflow.
REQ-034 With SPI_RX_DROP_CNT_EN undefined: no drop_cnt port, no counter logic; all other behaviour identical.

Structure
REQ-035 Shared package spi_pkg SHALL hold SPI_WORD_W=12 and the capture FSM state typedef (ARMED, HOLD).
REQ-036 The FIFO SHALL be a separate sub-module, spi_sync_fifo, parameterized by width and depth.
REQ-037 spi_rx_buffer SHALL contain the synchronizer, the capture FSM and the overflow/drop-counter logic.

Verification
REQ-038 Single frame: dout=12'hA5C, done high for 22 cycles, rx_ready=0 -> rx_valid rises 3 cycles after done, rx_data=12'hA5C, level=1, exactly one push.
REQ-039 Burst: 8 frames 12'h001..12'h008, rx_ready=0 -> full=1, level=8; then rx_ready=1 -> words drain in order 001..008, rx_valid=0 after the 8th.
REQ-040 Overflow: full FIFO, 9th frame 12'hFFF -> word dropped, overflow=1, drop_cnt=1 (if enabled); ovf_clr -> overflow=0, drop_cnt=0.
REQ-041 Simultaneous: full FIFO, rx_ready=1 in the push cycle of frame 12'h123 -> no drop, level stays 8, 12'h123 is read last.
REQ-042 Reset mid-operation: level=5, assert rst asynchronously -> rx_valid=0, level=0 immediately; next frame 12'h3C3 -> level=1, rx_data=12'h3C3.

Source files
------------

// File: rtl/spi_rx_buffer_pkg.sv
// Shared definitions for the SPI receive path: word width, capture FSM states,
// and a saturating 8-bit increment.
package spi_pkg;

   localparam int SPI_WORD_W = 12;

   typedef enum logic {
      ARMED = 1'b0,
      HOLD  = 1'b1
   } cap_state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/spi_rx_buffer_if.sv
// Consumer-side bundle of the SPI receive buffer.
// The drop_cnt signal exists only when SPI_RX_DROP_CNT_EN is defined.
interface spi_rx_buffer_if import spi_pkg::*; #(parameter int DEPTH = 8);

   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic                  done;
   logic [SPI_WORD_W-1:0] dout;
   logic                  rx_ready;
   logic                  ovf_clr;
   logic [SPI_WORD_W-1:0] rx_data;
   logic                  rx_valid;
   logic [LVL_W-1:0]      level;
   logic                  full;
   logic                  overflow;
`ifdef SPI_RX_DROP_CNT_EN
   logic [7:0]            drop_cnt;

   modport master (output done, dout, rx_ready, ovf_clr,
                   input  rx_data, rx_valid, level, full, overflow, drop_cnt);
   modport slave  (input  done, dout, rx_ready, ovf_clr,
                   output rx_data, rx_valid, level, full, overflow, drop_cnt);
`else
   modport master (output done, dout, rx_ready, ovf_clr,
                   input  rx_data, rx_valid, level, full, overflow);
   modport slave  (input  done, dout, rx_ready, ovf_clr,
                   output rx_data, rx_valid, level, full, overflow);
`endif

endinterface

// File: rtl/spi_rx_buffer_fifo.sv
// First-word-fall-through synchronous FIFO; occupancy is tracked by an explicit
// level counter so full/empty never depend on pointer comparison.
module spi_sync_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             do_wr;
   logic             do_rd;

   assign empty   = (level_q == '0);
   assign full    = (level_q == LVL_W'(DEPTH));
   assign level   = level_q;
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

   // A write into a full FIFO is allowed only when a read frees the slot in the same cycle.
   always_comb begin
      do_rd    = rd_en && !empty;
      do_wr    = wr_en && (!full || do_rd);
      wr_ptr_d = do_wr ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = do_rd ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      level_d  = level_q;
      case ({do_wr, do_rd})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: rtl/spi_rx_buffer.sv
// SPI receive buffer: synchronizes the slave's done level, pushes one word per frame
// into a FIFO and flags dropped frames. Optional drop counter: SPI_RX_DROP_CNT_EN.
module spi_rx_buffer import spi_pkg::*; #(
   parameter int DEPTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   spi_rx_buffer_if.slave  bus
);

   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   cap_state_e             state_q, state_d;
   logic                   overflow_q, overflow_d;
   logic                   done_s;
   logic                   push;
   logic                   pop;
   logic                   drop;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [LVL_W-1:0]       fifo_level;

   assign done_s = sync_q[SYNC_STAGES-1];

   // Push fires in the cycle the synchronized level is first seen high, so the word
   // lands in the FIFO on that same edge and rx_valid follows SYNC_STAGES+1 edges after done.
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], bus.done};
      state_d = state_q;
      push    = 1'b0;
      case (state_q)
         ARMED: begin
            if (done_s) begin
               push    = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (!done_s) begin
               state_d = ARMED;
            end
         end
         default: state_d = ARMED;
      endcase
   end

   always_comb begin
      pop        = !fifo_empty && bus.rx_ready;
      drop       = push && fifo_full && !pop;
      overflow_d = drop ? 1'b1 : (bus.ovf_clr ? 1'b0 : overflow_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q     <= '0;
         state_q    <= ARMED;
         overflow_q <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         state_q    <= state_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef SPI_RX_DROP_CNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   // A drop in the same cycle as ovf_clr wins, mirroring the overflow flag.
   always_comb begin
      drop_cnt_d = drop ? sat_inc8(drop_cnt_q) : (bus.ovf_clr ? 8'h00 : drop_cnt_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt_q <= 8'h00;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign bus.drop_cnt = drop_cnt_q;
`endif

   spi_sync_fifo #(
      .WIDTH (SPI_WORD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (bus.dout),
      .rd_en   (bus.rx_ready),
      .rd_data (bus.rx_data),
      .level   (fifo_level),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign bus.rx_valid = !fifo_empty;
   assign bus.level    = fifo_level;
   assign bus.full     = fifo_full;
   assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_spi_rx_buffer.sv
// Self-checking bench for spi_rx_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_spi_rx_buffer;
   import spi_pkg::*;

   localparam int DEPTH = 8;
   localparam int SYNC  = 2;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   spi_rx_buffer_if #(.DEPTH(DEPTH)) bus();

   spi_rx_buffer #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Reference model: a frame is seen SYNC edges after done is sampled; a push happens on
   // the first such edge of each high pulse. Pop precedes push, so a full FIFO can accept a
   // word only when it is also being read.
   logic [11:0] mq[$];
   bit          m_ovf;
   int          m_drop;
   bit [SYNC:0] dh;

   always @(posedge clk or posedge rst) begin
      bit m_push, m_pop, m_full, m_dropnow;
      if (rst) begin
         mq.delete();
         m_ovf  = 1'b0;
         m_drop = 0;
         dh     = '0;
      end else begin
         m_push    = dh[SYNC-1] && !dh[SYNC];
         dh        = {dh[SYNC-1:0], bus.done};
         m_pop     = (mq.size() > 0) && bus.rx_ready;
         m_full    = (mq.size() == DEPTH);
         m_dropnow = m_push && m_full && !m_pop;
         if (m_pop) void'(mq.pop_front());
         if (m_push && !m_dropnow) mq.push_back(bus.dout);
         if (m_dropnow) begin
            m_ovf  = 1'b1;
            m_drop = (m_drop == 255) ? 255 : m_drop + 1;
         end else if (bus.ovf_clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
         end
      end
   end

   task automatic frame(input logic [11:0] w, input int hi, input int lo);
      bus.dout = w;
      bus.done = 1'b1;
      repeat (hi) @(negedge clk);
      bus.done = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.done     = 1'b0;
      bus.dout     = '0;
      bus.rx_ready = 1'b0;
      bus.ovf_clr  = 1'b0;
      repeat (2) @(negedge clk);
      total += 5;
      if (bus.rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rx_valid got=%b want=0", bus.rx_valid); end
      if (bus.full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full got=%b want=0", bus.full); end
      if (bus.level !== 4'd0) begin bad++; $display("[TB] FAIL reset_level got=%0d want=0", bus.level); end
      if (bus.overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow got=%b want=0", bus.overflow); end
      if (bus.rx_data !== 12'h000) begin bad++; $display("[TB] FAIL reset_rx_data got=%h want=000", bus.rx_data); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_frame();
      bus.dout = 12'hA5C;
      bus.done = 1'b1;
      for (int e = 1; e <= 3; e++) begin
         @(negedge clk);
         total++;
         if (bus.rx_valid !== (e == 3)) begin
            bad++;
            $display("[TB] FAIL latency_edge%0d got=%b want=%b", e, bus.rx_valid, (e == 3));
         end
      end
      total += 2;
      if (bus.rx_data !== 12'hA5C) begin bad++; $display("[TB] FAIL single_data got=%h want=A5C", bus.rx_data); end
      if (bus.level !== 4'd1) begin bad++; $display("[TB] FAIL single_level got=%0d want=1", bus.level); end
      repeat (19) @(negedge clk);
      bus.done = 1'b0;
      repeat (6) @(negedge clk);
      total++;
      if (bus.level !== 4'd1) begin bad++; $display("[TB] FAIL single_one_push got=%0d want=1", bus.level); end
      bus.rx_ready = 1'b1;
      @(negedge clk);
      bus.rx_ready = 1'b0;
      total++;
      if (bus.rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_drain got=%b want=0", bus.rx_valid); end
   endtask

   task automatic test_burst();
      for (int i = 1; i <= 8; i++) frame(12'(i), 3, 4);
      total += 2;
      if (bus.full !== 1'b1) begin bad++; $display("[TB] FAIL burst_full got=%b want=1", bus.full); end
      if (bus.level !== 4'd8) begin bad++; $display("[TB] FAIL burst_level got=%0d want=8", bus.level); end
      bus.rx_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         total++;
         if (bus.rx_valid !== 1'b1 || bus.rx_data !== 12'(i)) begin
            bad++;
            $display("[TB] FAIL burst_order%0d got=%b/%h want=1/%h", i, bus.rx_valid, bus.rx_data, 12'(i));
         end
         @(negedge clk);
      end
      total++;
      if (bus.rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL burst_empty got=%b want=0", bus.rx_valid); end
      bus.rx_ready = 1'b0;
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 8; i++) frame(12'h010 + 12'(i), 2, 4);
      frame(12'hFFF, 4, 5);
      total += 3;
      if (bus.overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_set got=%b want=1", bus.overflow); end
      if (bus.level !== 4'd8) begin bad++; $display("[TB] FAIL ovf_level got=%0d want=8", bus.level); end
      if (bus.rx_data !== 12'h010) begin bad++; $display("[TB] FAIL ovf_head got=%h want=010", bus.rx_data); end
`ifdef SPI_RX_DROP_CNT_EN
      total++;
      if (bus.drop_cnt !== 8'(m_drop) || m_drop != 1) begin bad++; $display("[TB] FAIL ovf_drop_cnt got=%0d want=1", bus.drop_cnt); end
`endif
      bus.ovf_clr = 1'b1;
      @(negedge clk);
      bus.ovf_clr = 1'b0;
      total++;
      if (bus.overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clear got=%b want=0", bus.overflow); end
`ifdef SPI_RX_DROP_CNT_EN
      total++;
      if (bus.drop_cnt !== 8'h00) begin bad++; $display("[TB] FAIL ovf_drop_clear got=%0d want=0", bus.drop_cnt); end
`endif
      bus.rx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (bus.rx_data !== 12'h010 + 12'(i)) begin
            bad++;
            $display("[TB] FAIL ovf_contents%0d got=%h want=%h", i, bus.rx_data, 12'h010 + 12'(i));
         end
         @(negedge clk);
      end
      bus.rx_ready = 1'b0;
   endtask

   task automatic test_simultaneous();
      logic [11:0] last;
      for (int i = 0; i < 8; i++) frame(12'h020 + 12'(i), 2, 4);
      bus.dout = 12'h123;
      bus.done = 1'b1;
      repeat (2) @(negedge clk);
      bus.rx_ready = 1'b1;
      @(negedge clk);
      bus.rx_ready = 1'b0;
      total += 2;
      if (bus.level !== 4'd8) begin bad++; $display("[TB] FAIL simul_level got=%0d want=8", bus.level); end
      if (bus.overflow !== 1'b0) begin bad++; $display("[TB] FAIL simul_no_drop got=%b want=0", bus.overflow); end
      bus.done = 1'b0;
      repeat (5) @(negedge clk);
      bus.rx_ready = 1'b1;
      last = 12'h000;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (bus.rx_data !== mq[0]) begin bad++; $display("[TB] FAIL simul_order%0d got=%h want=%h", i, bus.rx_data, mq[0]); end
         last = bus.rx_data;
         @(negedge clk);
      end
      bus.rx_ready = 1'b0;
      total++;
      if (last !== 12'h123) begin bad++; $display("[TB] FAIL simul_last got=%h want=123", last); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) frame(12'h050 + 12'(i), 2, 4);
      total++;
      if (bus.level !== 4'd5) begin bad++; $display("[TB] FAIL rmid_pre_level got=%0d want=5", bus.level); end
      #3 rst = 1'b1;
      #1;
      total += 2;
      if (bus.rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL rmid_valid got=%b want=0", bus.rx_valid); end
      if (bus.level !== 4'd0) begin bad++; $display("[TB] FAIL rmid_level got=%0d want=0", bus.level); end
      @(negedge clk);
      rst = 1'b0;
      frame(12'h3C3, 3, 5);
      total += 2;
      if (bus.level !== 4'd1) begin bad++; $display("[TB] FAIL rmid_post_level got=%0d want=1", bus.level); end
      if (bus.rx_data !== 12'h3C3) begin bad++; $display("[TB] FAIL rmid_post_data got=%h want=3C3", bus.rx_data); end
      // done held across reset release must be captured as a fresh frame
      bus.dout = 12'h7E1;
      bus.done = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      bus.done = 1'b0;
      repeat (5) @(negedge clk);
      total += 2;
      if (bus.level !== 4'd1) begin bad++; $display("[TB] FAIL rel_high_level got=%0d want=1", bus.level); end
      if (bus.rx_data !== 12'h7E1) begin bad++; $display("[TB] FAIL rel_high_data got=%h want=7E1", bus.rx_data); end
      bus.rx_ready = 1'b1;
      @(negedge clk);
      bus.rx_ready = 1'b0;
   endtask

   task automatic test_random();
      int hi_left = 0;
      int lo_left = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         total += 4;
         if (bus.level !== 4'(mq.size())) begin bad++; $display("[TB] FAIL rand_level c=%0d got=%0d want=%0d", c, bus.level, mq.size()); end
         if (bus.rx_valid !== (mq.size() > 0)) begin bad++; $display("[TB] FAIL rand_valid c=%0d got=%b want=%b", c, bus.rx_valid, mq.size() > 0); end
         if (bus.full !== (mq.size() == DEPTH)) begin bad++; $display("[TB] FAIL rand_full c=%0d got=%b want=%b", c, bus.full, mq.size() == DEPTH); end
         if (bus.overflow !== m_ovf) begin bad++; $display("[TB] FAIL rand_ovf c=%0d got=%b want=%b", c, bus.overflow, m_ovf); end
`ifdef SPI_RX_DROP_CNT_EN
         total++;
         if (bus.drop_cnt !== 8'(m_drop)) begin bad++; $display("[TB] FAIL rand_drop_cnt c=%0d got=%0d want=%0d", c, bus.drop_cnt, m_drop); end
`endif
         if (mq.size() > 0) begin
            total++;
            if (bus.rx_data !== mq[0]) begin bad++; $display("[TB] FAIL rand_data c=%0d got=%h want=%h", c, bus.rx_data, mq[0]); end
         end
         bus.rx_ready = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         bus.ovf_clr  = ($urandom_range(0, 15) == 0);
         if (bus.done) begin
            hi_left--;
            if (hi_left == 0) begin
               bus.done = 1'b0;
               lo_left  = $urandom_range(4, 7);
            end
         end else if (lo_left > 0) begin
            lo_left--;
         end else if ($urandom_range(0, 1) == 1) begin
            bus.dout = 12'($urandom);
            bus.done = 1'b1;
            hi_left  = $urandom_range(1, 6);
         end
      end
      bus.done     = 1'b0;
      bus.ovf_clr  = 1'b0;
      bus.rx_ready = 1'b1;
      repeat (20) @(negedge clk);
      total++;
      if (bus.rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL rand_final_empty got=%b want=0", bus.rx_valid); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_burst();
      test_overflow();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
